// File: rtl/qarma64_pkg.sv
// Shared types, cell tables and per-cell helpers for the QARMA-64 tweak schedule.
// Optional feature macro QARMA64_TWK_INV_EN adds the inverse cell LFSR helper.
// Cell c occupies tweak bits [63-4c -: 4]; cell 0 is the top nibble.
package qarma64_pkg;

    localparam int unsigned TWEAK_W = 64;
    localparam int unsigned CELL_W  = 4;
    localparam int unsigned N_CELLS = 16;
    localparam int unsigned IDX_W   = 4;

    typedef logic [CELL_W-1:0]  cell_t;
    typedef logic [TWEAK_W-1:0] tweak_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // h: out cell c = in cell H_PERM[c]; H_INV undoes it the same way.
    localparam cell_t H_PERM [N_CELLS] = '{
        4'd6, 4'd5, 4'd14, 4'd15, 4'd0,  4'd1,  4'd2,  4'd3,
        4'd7, 4'd12, 4'd13, 4'd4, 4'd8,  4'd9,  4'd10, 4'd11
    };
    localparam cell_t H_INV [N_CELLS] = '{
        4'd4,  4'd5,  4'd6,  4'd7,  4'd11, 4'd1,  4'd0,  4'd8,
        4'd12, 4'd13, 4'd14, 4'd15, 4'd9,  4'd10, 4'd2,  4'd3
    };

    // Bit (15-c) set means cell c goes through the LFSR.
    localparam logic [N_CELLS-1:0] LFSR_CELL_MASK = 16'b1101_1000_1001_0100;

    function automatic cell_t get_cell(input tweak_t t, input cell_t c);
        return t[TWEAK_W-1-CELL_W*32'(c) -: CELL_W];
    endfunction

    function automatic logic cell_in_lfsr(input cell_t c);
        return LFSR_CELL_MASK[4'd15 - c];
    endfunction

    // {b3,b2,b1,b0} -> {b0^b1,b3,b2,b1}
    function automatic cell_t lfsr_fwd(input cell_t x);
        return {x[0] ^ x[1], x[3:1]};
    endfunction

`ifdef QARMA64_TWK_INV_EN
    // {b3,b2,b1,b0} -> {b2,b1,b0,b3^b0}
    function automatic cell_t lfsr_inv(input cell_t x);
        return {x[2:0], x[3] ^ x[0]};
    endfunction
`endif

    // Elaboration-time sanity check that the two permutation tables agree.
    function automatic logic h_tables_consistent();
        logic ok;
        ok = 1'b1;
        for (int unsigned c = 0; c < N_CELLS; c++) begin
            if (H_INV[H_PERM[c]] != 4'(c)) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/qarma64_tweak_step.sv
// One QARMA-64 tweak-schedule step, purely combinational.
// Forward: next = LFSR(h(tweak)). With QARMA64_TWK_INV_EN, dir=1 selects
// next = h^-1(InvLFSR(tweak)); without the macro only the forward path exists.
// Ports: tweak (in, 64), dir (in, 1, macro only), next (out, 64).
module qarma64_tweak_step
    import qarma64_pkg::*;
(
    input  tweak_t tweak,
`ifdef QARMA64_TWK_INV_EN
    input  logic   dir,
`endif
    output tweak_t next
);

    tweak_t h_fwd;
    tweak_t fwd_next;

    // Cell permutation h (gather form).
    always_comb begin
        h_fwd = '0;
        for (int unsigned c = 0; c < N_CELLS; c++) begin
            h_fwd[TWEAK_W-1-CELL_W*c -: CELL_W] = get_cell(tweak, H_PERM[c]);
        end
    end

    // Cell LFSR on the masked cells; the rest pass through.
    always_comb begin
        fwd_next = h_fwd;
        for (int unsigned c = 0; c < N_CELLS; c++) begin
            if (cell_in_lfsr(4'(c))) begin
                fwd_next[TWEAK_W-1-CELL_W*c -: CELL_W] = lfsr_fwd(get_cell(h_fwd, 4'(c)));
            end
        end
    end

`ifdef QARMA64_TWK_INV_EN
    tweak_t lfsr_inv_t;
    tweak_t inv_next;

    // Inverse LFSR first, undoing the last forward operation.
    always_comb begin
        lfsr_inv_t = tweak;
        for (int unsigned c = 0; c < N_CELLS; c++) begin
            if (cell_in_lfsr(4'(c))) begin
                lfsr_inv_t[TWEAK_W-1-CELL_W*c -: CELL_W] = lfsr_inv(get_cell(tweak, 4'(c)));
            end
        end
    end

    // h^-1: out cell H_PERM[c] = in cell c, written as a gather through H_INV.
    always_comb begin
        inv_next = '0;
        for (int unsigned c = 0; c < N_CELLS; c++) begin
            inv_next[TWEAK_W-1-CELL_W*c -: CELL_W] = get_cell(lfsr_inv_t, H_INV[c]);
        end
    end

    assign next = dir ? inv_next : fwd_next;
`else
    assign next = fwd_next;
`endif

endmodule

// File: rtl/qarma64_tweak_sched.sv
// Iterative QARMA-64 tweak-schedule generator: loads T_0 and emits
// T_0..T_{ROUNDS-1}, one per accepted beat, to the round datapath.
// Optional feature macro QARMA64_TWK_INV_EN adds in_dir (backward schedule).
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready/in_tweak[63:0] (/in_dir) : tweak load handshake
//   out_valid/out_ready/out_tweak[63:0]/out_idx[3:0]/out_last : round tweak stream
module qarma64_tweak_sched
    import qarma64_pkg::*;
#(
    parameter int unsigned ROUNDS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_tweak,
`ifdef QARMA64_TWK_INV_EN
    input  logic        in_dir,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_tweak,
    output logic [3:0]  out_idx,
    output logic        out_last
);

    if (ROUNDS < 2 || ROUNDS > 15) begin : g_bad_rounds
        $error("qarma64_tweak_sched: ROUNDS must be in 2..15");
    end
    if (!h_tables_consistent()) begin : g_bad_perm
        $error("qarma64_tweak_sched: H_INV is not the inverse of H_PERM");
    end

    localparam idx_t LAST_IDX = 4'(ROUNDS - 1);

    state_t state_q, state_d;
    tweak_t tweak_q, tweak_d;
    idx_t   idx_q,   idx_d;
    logic   in_ready_q,  in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   out_last_q,  out_last_d;
    tweak_t step_next;

`ifdef QARMA64_TWK_INV_EN
    logic   dir_q, dir_d;

    qarma64_tweak_step u_step (
        .tweak (tweak_q),
        .dir   (dir_q),
        .next  (step_next)
    );
`else
    qarma64_tweak_step u_step (
        .tweak (tweak_q),
        .next  (step_next)
    );
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tweak_q     <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef QARMA64_TWK_INV_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tweak_q     <= tweak_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef QARMA64_TWK_INV_EN
            dir_q       <= dir_d;
`endif
        end
    end

    // Next state, datapath update and next registered outputs.
    always_comb begin
        state_d = state_q;
        tweak_d = tweak_q;
        idx_d   = idx_q;
`ifdef QARMA64_TWK_INV_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = RUN;
                    tweak_d = in_tweak;
                    idx_d   = '0;
`ifdef QARMA64_TWK_INV_EN
                    dir_d   = in_dir;
`endif
                end
            end
            RUN: begin
                // Stalled beats leave everything untouched.
                if (out_valid_q && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        tweak_d = step_next;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == RUN);
        out_last_d  = (state_d == RUN) && (idx_d == LAST_IDX);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_tweak = tweak_q;
    assign out_idx   = idx_q;
    assign out_last  = out_last_q;

endmodule
